ram_arbiter_2p: RTL
===================

Name: ram_arbiter_2p

Overview:
- Two-requester arbiter/sequencer in front of one RAM_4Kx32-style single-port macro (32-bit data, 12-bit word address, 4 byte-write enables, synchronous read).
- Accepts one command at a time from either requester and drives the macro's EN/WE/A/Di.
- Holds A stable through the read-response cycle, because the macro's bank output mux is selected by the current A.
- Returns read data to the owning requester with a one-cycle RVALID pulse.

Parameters:
- AW, 12, word address width (matches macro A).
- DW, 32, data width (matches macro Di/Do).
- WEW, 4, byte-write-enable width; fixed at DW/8.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RSTn  in  1  asynchronous active-low reset.
- R0_VALID  in  1  requester 0 command valid.
- R0_READY  out  1  requester 0 command accepted this cycle.
- R0_WE  in  WEW  requester 0 byte enables; 0 = read, nonzero = write.
- R0_A  in  AW  requester 0 word address.
- R0_DI  in  DW  requester 0 write data.
- R0_RVALID  out  1  requester 0 read data valid (1-cycle pulse).
- R0_DO  out  DW  requester 0 read data.
- R1_VALID, R1_READY, R1_WE, R1_A, R1_DI, R1_RVALID, R1_DO: same as requester 0, for requester 1.
- RAM_EN  out  1  macro enable.
- RAM_WE  out  WEW  macro byte write enables.
- RAM_A  out  AW  macro address.
- RAM_DI  out  DW  macro write data.
- RAM_DO  in  DW  macro read data (valid the cycle after the EN edge, while A is held).

Behaviour:
- FSM states IDLE, ACCESS, RESP. Reset (RSTn=0, asynchronous):
  - state=IDLE, cmd regs cleared, owner=0, last_grant=1 (port 0 wins the first tie).
  - RAM_EN=0, RAM_WE=0, RAM_A=0, RAM_DI=0.
  - R*_READY=0, R*_RVALID=0.
- IDLE:
  - Grant is combinational from R0_VALID/R1_VALID.
  - If only one is valid, it wins. If both are valid, the one not equal to last_grant wins (round-robin).
  - Winner's READY=1 in the same cycle; loser's READY=0. READY is never asserted outside IDLE.
  - On the edge with VALID&READY: latch WE/A/DI into cmd regs, set owner and last_grant to the winner, go to ACCESS.
  - With no request, stay in IDLE; RAM_EN=0.
- ACCESS (1 cycle):
  - RAM_EN=1, RAM_WE=cmd_WE, RAM_A=cmd_A, RAM_DI=cmd_DI.
  - If cmd_WE!=0 (write), next state is IDLE; writes produce no RVALID.
  - Otherwise (read), next state is RESP.
- RESP (1 cycle):
  - RAM_EN=0, RAM_WE=0, RAM_A held at cmd_A.
  - Owner's RVALID=1 and owner's DO=RAM_DO; the other port's RVALID=0.
  - Next state is IDLE.
- Latency and throughput:
  - Write: accept edge plus 1 cycle; one write per 2 cycles.
  - Read: data appears 2 cycles after the accept edge; one read per 3 cycles.
- Outputs outside their defined cycles:
  - RAM_A/RAM_DI keep their last value when idle; RAM_EN and RAM_WE are 0 outside ACCESS.
  - R*_DO is a don't-care when RVALID=0; the implementation drives RAM_DO to both ports.
- Boundary conditions:
  - Requesters must hold VALID and payload until READY; the arbiter samples the payload only on the accept edge.
  - A VALID that drops before READY is simply not served.
  - Full address range 0..4095 is passed through unmodified; no wrap or decode inside the block.
  - Reset mid-ACCESS: the in-flight write may or may not complete in the macro. Reset mid-RESP: RVALID is suppressed. No response is ever issued after reset.

Optional Feature:
- Macro RAM_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both are valid; last_grant is still tracked but ignored.
- Undefined (default): round-robin as specified above.

Test Plan:
- Reset, then R0 write A=0x000 WE=4'hF DI=0xDEADBEEF, then R0 read A=0x000 -> read has R0_RVALID 2 cycles after accept with R0_DO=0xDEADBEEF; ACCESS cycles show RAM_EN=1; RESP cycle shows RAM_A=0x000.
- Write all four 1K banks (A=0x3FF, 0x400, 0xBFF, 0xC00) with distinct data, then read back with R1 -> each R1_DO matches its address; RAM_A held through RESP.
- Byte write: R0 writes 0x11223344 WE=4'hF to A=0x123, then writes 0xAABBCCDD WE=4'b0101, then reads -> 0x11BB33DD.
- R0 and R1 both continuously issue reads -> grants alternate 0,1,0,1 starting with 0; no RVALID on the non-owner. With RAM_ARB_FIXED_PRIO_EN defined -> R0 wins every grant.
- RSTn pulsed low during RESP of an R1 read -> R1_RVALID stays 0; RAM_EN=0; next request is accepted from IDLE with port 0 winning a tie.
- Idle bench with no VALID for 20 cycles -> RAM_EN=0 and RAM_WE=0 every cycle; READY stays 0.

Source files
------------

// File: rtl/ram_arbiter_2p.sv
// ram_arbiter_2p
//   Two-requester arbiter/sequencer in front of a single-port synchronous-read
//   RAM macro (RAM_4Kx32 style). One command is in flight at a time. A read
//   takes IDLE -> ACCESS -> RESP. A write takes IDLE -> ACCESS. The macro
//   address stays at the command address through RESP because the macro's bank
//   output mux is steered by the live address.
//
// Optional build macro:
//   RAM_ARB_FIXED_PRIO_EN - requester 0 always wins a tie. last_grant is still
//                           updated but does not affect the choice. When the
//                           macro is undefined, ties are broken round-robin.
//
// Ports:
//   CLK, RSTn          clock and asynchronous active-low reset
//   Rn_VALID/READY     command handshake for requester n (READY only in IDLE)
//   Rn_WE/A/DI         command payload (WE == 0 means read)
//   Rn_RVALID/DO       one-cycle read response (DO carries RAM_DO to both ports)
//   RAM_EN/WE/A/DI     macro command outputs
//   RAM_DO             macro read data, valid the cycle after the EN edge

module ram_arbiter_2p #(
    parameter int AW  = 12,
    parameter int DW  = 32,
    parameter int WEW = DW / 8
) (
    input  logic           CLK,
    input  logic           RSTn,

    input  logic           R0_VALID,
    output logic           R0_READY,
    input  logic [WEW-1:0] R0_WE,
    input  logic [AW-1:0]  R0_A,
    input  logic [DW-1:0]  R0_DI,
    output logic           R0_RVALID,
    output logic [DW-1:0]  R0_DO,

    input  logic           R1_VALID,
    output logic           R1_READY,
    input  logic [WEW-1:0] R1_WE,
    input  logic [AW-1:0]  R1_A,
    input  logic [DW-1:0]  R1_DI,
    output logic           R1_RVALID,
    output logic [DW-1:0]  R1_DO,

    output logic           RAM_EN,
    output logic [WEW-1:0] RAM_WE,
    output logic [AW-1:0]  RAM_A,
    output logic [DW-1:0]  RAM_DI,
    input  logic [DW-1:0]  RAM_DO
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [WEW-1:0] cmd_we_reg, cmd_we_next;
    logic [AW-1:0]  cmd_a_reg, cmd_a_next;
    logic [DW-1:0]  cmd_di_reg, cmd_di_next;
    logic           owner_reg, owner_next;
    logic           last_grant_reg, last_grant_next;

    logic [1:0]     req;
    logic [1:0]     grant;
    logic [1:0]     rvalid;
    logic           prefer_r1;
    logic           ram_en;
    logic [WEW-1:0] ram_we;

    assign req = {R1_VALID, R0_VALID};

    // Tie-break choice. Port 1 wins a tie only when port 0 had the last grant.
`ifdef RAM_ARB_FIXED_PRIO_EN
    assign prefer_r1 = 1'b0;
`else
    assign prefer_r1 = (last_grant_reg == 1'b0);
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_reg      <= IDLE;
            cmd_we_reg     <= '0;
            cmd_a_reg      <= '0;
            cmd_di_reg     <= '0;
            owner_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            cmd_we_reg     <= cmd_we_next;
            cmd_a_reg      <= cmd_a_next;
            cmd_di_reg     <= cmd_di_next;
            owner_reg      <= owner_next;
            last_grant_reg <= last_grant_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cmd_we_next     = cmd_we_reg;
        cmd_a_next      = cmd_a_reg;
        cmd_di_next     = cmd_di_reg;
        owner_next      = owner_reg;
        last_grant_next = last_grant_reg;
        grant           = 2'b00;
        rvalid          = 2'b00;
        ram_en          = 1'b0;
        ram_we          = '0;

        unique case (state_reg)
            IDLE: begin
                if (req[1] && (!req[0] || prefer_r1)) begin
                    grant = 2'b10;
                end else if (req[0]) begin
                    grant = 2'b01;
                end

                if (grant[1]) begin
                    cmd_we_next     = R1_WE;
                    cmd_a_next      = R1_A;
                    cmd_di_next     = R1_DI;
                    owner_next      = 1'b1;
                    last_grant_next = 1'b1;
                    state_next      = ACCESS;
                end else if (grant[0]) begin
                    cmd_we_next     = R0_WE;
                    cmd_a_next      = R0_A;
                    cmd_di_next     = R0_DI;
                    owner_next      = 1'b0;
                    last_grant_next = 1'b0;
                    state_next      = ACCESS;
                end
            end

            ACCESS: begin
                ram_en = 1'b1;
                ram_we = cmd_we_reg;
                // Writes complete in the macro on this edge; only reads need RESP.
                state_next = (cmd_we_reg != '0) ? IDLE : RESP;
            end

            RESP: begin
                rvalid[owner_reg] = 1'b1;
                state_next        = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The address and data come straight from the command registers. RAM_A
    // therefore stays put through RESP and while idle, which the macro's
    // output bank mux relies on.
    assign RAM_EN    = ram_en;
    assign RAM_WE    = ram_we;
    assign RAM_A     = cmd_a_reg;
    assign RAM_DI    = cmd_di_reg;

    assign R0_READY  = grant[0];
    assign R1_READY  = grant[1];
    assign R0_RVALID = rvalid[0];
    assign R1_RVALID = rvalid[1];
    assign R0_DO     = RAM_DO;
    assign R1_DO     = RAM_DO;

endmodule
